// File: rtl/matrix_pkg.sv
// Shared definitions for the NxN matrix multiplier.
//   state_t     : controller states (ST_IDLE, ST_COMPUTE, ST_DONE)
//   calc_rw     : result element width, wide enough that no sum can overflow
//   clog2_min1  : index counter width, never below one bit
package matrix_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   // A dot product of N terms of 2*DW-bit products needs clog2(N) growth bits.
   function automatic int calc_rw(input int n, input int dw);
      return (n <= 1) ? 2 * dw : 2 * dw + $clog2(n);
   endfunction

   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/matrix_mac_lane.sv
// One multiply-accumulate lane: one multiplier feeding an RW-bit accumulator.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : alone clears the accumulator; with en, loads the product alone
//   en       : adds the current product into the accumulator
//   a, b     : DW-bit operands (two's complement when SIGNED != 0)
//   acc      : running total including this cycle's product (acc_q + a*b),
//              so a row can be written out on its final term without waiting
module matrix_mac_lane #(
   parameter int DW     = 8,
   parameter int RW     = 17,
   parameter int SIGNED = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [RW-1:0] acc
);

   logic [2*DW-1:0] prod;
   logic [RW-1:0]   prod_ext;
   logic [RW-1:0]   acc_q;

   // Extending both operands to 2*DW first makes the low 2*DW bits of an
   // unsigned multiply equal the true signed or unsigned product.
   generate
      if (SIGNED != 0) begin : g_sgn
         logic [2*DW-1:0] a_x, b_x;
         assign a_x      = {{DW{a[DW-1]}}, a};
         assign b_x      = {{DW{b[DW-1]}}, b};
         assign prod     = a_x * b_x;
         assign prod_ext = RW'($signed(prod));
      end else begin : g_uns
         logic [2*DW-1:0] a_x, b_x;
         assign a_x      = {{DW{1'b0}}, a};
         assign b_x      = {{DW{1'b0}}, b};
         assign prod     = a_x * b_x;
         assign prod_ext = RW'(prod);
      end
   endgenerate

   assign acc = acc_q + prod_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            acc_q <= '0;
      else if (clr && en) acc_q <= prod_ext;
      else if (clr)       acc_q <= '0;
      else if (en)        acc_q <= acc;
   end

endmodule

// File: rtl/matrix_mult_nxn.sv
// NxN matrix multiplier with valid/ready handshakes on both sides.
// N lanes compute one row of C per N cycles; the full product is ready
// N*N cycles after operands are accepted and held until taken.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a_flat, b_flat      : operands, element [r][c] at [(r*N+c)*DW +: DW]
//   out_valid/out_ready : result handshake (valid only in DONE)
//   c_flat              : product, element [r][c] at [(r*N+c)*RW +: RW]
//   busy                : high while computing
module matrix_mult_nxn import matrix_pkg::*; #(
   parameter int N      = 2,
   parameter int DW     = 8,
   parameter int SIGNED = 0,
   parameter int RW     = calc_rw(N, DW)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N*N*DW-1:0] a_flat,
   input  logic [N*N*DW-1:0] b_flat,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N*N*RW-1:0] c_flat,
   output logic              busy
);

   localparam int IW = clog2_min1(N);

   state_t          state, state_nxt;
   logic [IW-1:0]   i_q, k_q;
   logic [DW-1:0]   a_m [N][N];
   logic [DW-1:0]   b_m [N][N];
   logic [N-1:0][RW-1:0] row_sum;
   logic [N*N*RW-1:0] c_q;
   logic            accept, last_k, last_i, lane_clr, lane_en;

   assign accept = in_valid && in_ready;
   assign last_k = (k_q == IW'(N - 1));
   assign last_i = (i_q == IW'(N - 1));
   // Accumulators are cleared on accept and after each row's final term.
   assign lane_clr = accept || (busy && last_k);
   assign lane_en  = busy && !last_k;
   assign c_flat   = c_q;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_COMPUTE;
         end
         ST_COMPUTE: begin
            busy = 1'b1;
            if (last_k && last_i) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   generate
      for (genvar j = 0; j < N; j++) begin : g_lane
         matrix_mac_lane #(.DW(DW), .RW(RW), .SIGNED(SIGNED)) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (lane_clr),
            .en  (lane_en),
            .a   (a_m[i_q][k_q]),
            .b   (b_m[k_q][j]),
            .acc (row_sum[j])
         );
      end
   endgenerate

   // Operand capture lets the source change a_flat/b_flat right after accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               a_m[r][c] <= a_flat[(r*N+c)*DW +: DW];
               b_m[r][c] <= b_flat[(r*N+c)*DW +: DW];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         i_q   <= '0;
         k_q   <= '0;
         c_q   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            i_q <= '0;
            k_q <= '0;
         end else if (busy) begin
            if (last_k) begin
               k_q <= '0;
               // Wrap after the final row so the index never exceeds N-1.
               i_q <= last_i ? '0 : i_q + 1'b1;
               for (int j = 0; j < N; j++)
                  c_q[(int'(i_q)*N+j)*RW +: RW] <= row_sum[j];
            end else begin
               k_q <= k_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_matrix_mult_nxn.sv
module tb_matrix_mult_nxn;

   localparam int RW2 = 17;
   localparam int RW3 = 18;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // N=2 unsigned
   logic iv2, ir2, ov2, or2, bz2;
   logic [31:0] a2, b2;
   logic [67:0] c2, exp2;
   // N=2 signed
   logic ivs, irs, ovs, ors, bzs;
   logic [31:0] as, bs;
   logic [67:0] cs, exps;
   // N=3 unsigned
   logic iv3, ir3, ov3, or3, bz3;
   logic [71:0] a3, b3;
   logic [161:0] c3, exp3;

   matrix_mult_nxn #(.N(2), .DW(8), .SIGNED(0)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a_flat(a2), .b_flat(b2),
      .out_valid(ov2), .out_ready(or2), .c_flat(c2), .busy(bz2));
   matrix_mult_nxn #(.N(2), .DW(8), .SIGNED(1)) s2 (
      .clk(clk), .rst(rst), .in_valid(ivs), .in_ready(irs), .a_flat(as), .b_flat(bs),
      .out_valid(ovs), .out_ready(ors), .c_flat(cs), .busy(bzs));
   matrix_mult_nxn #(.N(3), .DW(8), .SIGNED(0)) u3 (
      .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a_flat(a3), .b_flat(b3),
      .out_valid(ov3), .out_ready(or3), .c_flat(c3), .busy(bz3));

   task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Pack element values (two's complement, w bits each) row-major.
   function automatic logic [161:0] pack(input int v[9], input int n, input int w);
      logic [161:0] r;
      r = '0;
      for (int e = 0; e < n*n; e++)
         for (int bt = 0; bt < w; bt++)
            r[e*w+bt] = v[e][bt];
      return r;
   endfunction

   // Reference model: textbook matrix product on integers.
   function automatic logic [161:0] mm(input int a[9], input int b[9], input int n, input int rw);
      int c[9];
      for (int e = 0; e < 9; e++) c[e] = 0;
      for (int r = 0; r < n; r++)
         for (int col = 0; col < n; col++)
            for (int t = 0; t < n; t++)
               c[r*n+col] += a[r*n+t] * b[t*n+col];
      return pack(c, n, rw);
   endfunction

   // Present operands and hold in_valid through one edge (the accept edge).
   task automatic start(input int w, input int a[9], input int b[9]);
      case (w)
         0: begin a2 = 32'(pack(a, 2, 8)); b2 = 32'(pack(b, 2, 8));
                  exp2 = 68'(mm(a, b, 2, RW2)); iv2 = 1'b1; end
         1: begin as = 32'(pack(a, 2, 8)); bs = 32'(pack(b, 2, 8));
                  exps = 68'(mm(a, b, 2, RW2)); ivs = 1'b1; end
         default: begin a3 = 72'(pack(a, 3, 8)); b3 = 72'(pack(b, 3, 8));
                  exp3 = mm(a, b, 3, RW3); iv3 = 1'b1; end
      endcase
      @(posedge clk); #1;
   endtask

   // Count edges until out_valid; lim on expiry (reported by the caller's check).
   task automatic wait_out(input int w, input int lim, output int cnt);
      cnt = 0;
      while (cnt < lim) begin
         @(posedge clk); #1;
         cnt++;
         if ((w == 0 && ov2) || (w == 1 && ovs) || (w == 2 && ov3)) break;
      end
   endtask

   // Every cycle a result is presented, it must match the model.
   always @(negedge clk) begin
      if (!rst && ov2) chk("u2_model", c2, exp2);
      if (!rst && ovs) chk("s2_model", cs, exps);
      if (!rst && ov3) chk("u3_model", c3, exp3);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int A1[9], B1[9], A2[9], B2[9], AF[9], AS[9], I3[9], B3[9], A5[9], B5[9], A6[9], B6[9];
      int cnt;
      logic [161:0] snap;
      A1 = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
      B1 = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
      AF = '{255, 255, 255, 255, 0, 0, 0, 0, 0};
      AS = '{-1, 2, 3, -4, 0, 0, 0, 0, 0};
      I3 = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
      B3 = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      A5 = '{2, 0, 1, 3, 0, 0, 0, 0, 0};
      B5 = '{4, 5, 6, 7, 0, 0, 0, 0, 0};
      A6 = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
      B6 = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
      A2 = A1; B2 = B1;
      rst = 1'b1;
      {iv2, ivs, iv3, or2, ors, or3} = '0;
      a2 = '0; b2 = '0; as = '0; bs = '0; a3 = '0; b3 = '0;
      exp2 = '0; exps = '0; exp3 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_u2", {ir2, ov2, bz2, c2}, {1'b1, 1'b0, 1'b0, 68'd0});
      chk("reset_s2", {irs, ovs, bzs, cs}, {1'b1, 1'b0, 1'b0, 68'd0});
      chk("reset_u3", {ir3, ov3, bz3, c3}, {1'b1, 1'b0, 1'b0, 162'd0});

      // Pin the model with hand-computed products.
      chk("model_t1", mm(A1, B1, 2, RW2), {17'd50, 17'd43, 17'd22, 17'd19});
      chk("model_t3", mm(AS, B1, 2, RW2), {17'h1FFF2, 17'h1FFF3, 17'd10, 17'd9});
      chk("model_t4", mm(I3, B3, 3, RW3), pack(B3, 3, RW3));

      // 1: basic product, latency, one-cycle out_valid, in_ready afterwards
      @(posedge clk); #1;
      or2 = 1'b1;
      start(0, A1, B1);
      iv2 = 1'b0; a2 = '1; b2 = '1;
      chk("t1_busy", {bz2, ir2}, 2'b10);
      wait_out(0, 20, cnt);
      chk("t1_latency", cnt, 4);
      chk("t1_result", c2, {17'd50, 17'd43, 17'd22, 17'd19});
      @(posedge clk); #1;
      chk("t1_release", {ov2, ir2}, 2'b01);

      // 2: full-scale unsigned, no truncation
      start(0, AF, AF);
      iv2 = 1'b0;
      wait_out(0, 20, cnt);
      chk("t2_latency", cnt, 4);
      chk("t2_result", c2, {4{17'd130050}});
      @(posedge clk); #1;

      // 3: signed
      ors = 1'b1;
      start(1, AS, B1);
      ivs = 1'b0;
      wait_out(1, 20, cnt);
      chk("t3_latency", cnt, 4);
      chk("t3_result", cs, {17'h1FFF2, 17'h1FFF3, 17'd10, 17'd9});
      @(posedge clk); #1;
      chk("t3_release", {ovs, irs}, 2'b01);

      // 4: N=3 identity, back-pressure hold, in_valid ignored in DONE
      or3 = 1'b0;
      start(2, I3, B3);
      iv3 = 1'b0;
      wait_out(2, 30, cnt);
      chk("t4_latency", cnt, 9);
      chk("t4_result", c3, pack(B3, 3, RW3));
      snap = c3;
      for (int h = 0; h < 10; h++) begin
         @(posedge clk); #1;
         if (h == 3) begin iv3 = 1'b1; a3 = '1; b3 = '1; end
         if (h == 4) iv3 = 1'b0;
         chk("t4_hold", {ov3, ir3, c3}, {1'b1, 1'b0, snap});
      end
      or3 = 1'b1;
      @(posedge clk); #1;
      chk("t4_release", {ov3, ir3}, 2'b01);
      or3 = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("t4_no_queue", {bz3, ov3, ir3}, 3'b001);

      // 5: reset mid-compute, then a clean job
      start(0, A1, B1);
      iv2 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1 chk("t5_reset", {ov2, ir2, bz2, c2}, {1'b0, 1'b1, 1'b0, 68'd0});
      @(posedge clk); #1 rst = 1'b0;
      start(0, A5, B5);
      iv2 = 1'b0;
      wait_out(0, 20, cnt);
      chk("t5_latency", cnt, 4);
      chk("t5_result", c2, {17'd26, 17'd22, 17'd10, 17'd8});
      @(posedge clk); #1;

      // 6: back-to-back with in_valid held and operands changed after accept
      start(0, A2, B2);
      a2 = 32'(pack(A6, 2, 8)); b2 = 32'(pack(B6, 2, 8));
      wait_out(0, 20, cnt);
      chk("t6_latency1", cnt, 4);
      chk("t6_result1", c2, {17'd50, 17'd43, 17'd22, 17'd19});
      @(posedge clk); #1;
      chk("t6_release", {ov2, ir2}, 2'b01);
      exp2 = 68'(mm(A6, B6, 2, RW2));
      @(posedge clk); #1;
      chk("t6_accept2", {bz2, ir2}, 2'b10);
      iv2 = 1'b0;
      wait_out(0, 20, cnt);
      chk("t6_latency2", cnt, 4);
      chk("t6_result2", c2, {17'd2, 17'd1, 17'd4, 17'd3});
      @(posedge clk); #1;
      or2 = 1'b0; ors = 1'b0;
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
